// File: rtl/conv_mac_array.sv
// LANES-wide signed MAC: each lane sums KLEN pixel*weight products, with optional ReLU, into a held result.
// out_valid rises on the edge accepting the KLEN-th beat; in HOLD in_ready=0 until the out_ready handshake.
module conv_mac_array #(
   parameter int DW = 8,
   parameter int KLEN = 9,
   parameter int LANES = 4,
   localparam int AW = 2*DW + $clog2(KLEN),
   localparam int CW = $clog2(KLEN+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  relu_en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DW-1:0]         pixel,
   input  logic [LANES*DW-1:0]   weights,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*AW-1:0]   out_data,
   output logic [CW-1:0]         beat_cnt,
   output logic                  busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]                   state_q, state_d;
   logic [LANES-1:0][AW-1:0]     acc_q, acc_d;
   logic [LANES-1:0][AW-1:0]     res_q, res_d;
   logic [LANES-1:0][AW-1:0]     sum;
   logic [LANES-1:0][2*DW-1:0]   w_ext, prod;
   logic [2*DW-1:0]              px_ext;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic                         ov_q, ov_d;
   logic                         accept, last_beat;

   assign in_ready  = (state_q != S_HOLD);
   assign busy      = (state_q != S_IDLE);
   assign accept    = in_valid && in_ready;
   assign last_beat = (cnt_q == CW'(KLEN-1));
   assign out_valid = ov_q;
   assign out_data  = res_q;
   assign beat_cnt  = cnt_q;

   // Operands are sign-extended to 2*DW so the low 2*DW bits of the product are the signed product.
   always_comb begin
      px_ext = {{DW{pixel[DW-1]}}, pixel};
      for (int i = 0; i < LANES; i++) begin
         w_ext[i] = {{DW{weights[i*DW+DW-1]}}, weights[i*DW +: DW]};
         prod[i]  = px_ext * w_ext[i];
         sum[i]   = ((state_q == S_IDLE) ? '0 : acc_q[i])
                    + {{(AW-2*DW){prod[i][2*DW-1]}}, prod[i]};
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      ov_d    = ov_q;
      if (clear) begin
         state_d = S_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ov_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  acc_d   = sum;
                  cnt_d   = CW'(1);
                  state_d = S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  if (last_beat) begin
                     for (int i = 0; i < LANES; i++)
                        res_d[i] = (relu_en && sum[i][AW-1]) ? '0 : sum[i];
                     acc_d   = '0;
                     cnt_d   = '0;
                     ov_d    = 1'b1;
                     state_d = S_HOLD;
                  end else begin
                     acc_d = sum;
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  ov_d    = 1'b0;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         ov_q    <= ov_d;
      end
   end

endmodule

// File: tb/tb_conv_mac_array.sv
// Randomised and directed checks of conv_mac_array against a sum-of-products window model.
module tb_conv_mac_array;
   localparam int DW = 8;
   localparam int KLEN = 9;
   localparam int LANES = 4;
   localparam int AW = 20;
   localparam int CW = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                clear = 1'b0;
   logic                relu_en = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [DW-1:0]       pixel = '0;
   logic [LANES*DW-1:0] weights = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [LANES*AW-1:0] out_data;
   logic [CW-1:0]       beat_cnt;
   logic                busy;

   int n_vec = 0;
   int n_err = 0;

   int pix_a [KLEN];
   int w_a   [KLEN][LANES];
   bit relu_a[KLEN];
   int exp_r [LANES];
   int last_r[LANES];

   conv_mac_array #(.DW(DW), .KLEN(KLEN), .LANES(LANES)) dut (
      .clk(clk), .rst(rst), .clear(clear), .relu_en(relu_en),
      .in_valid(in_valid), .in_ready(in_ready), .pixel(pixel), .weights(weights),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .beat_cnt(beat_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: full-precision dot product per lane; ReLU decided by the final beat's relu flag.
   task automatic compute_expected();
      for (int i = 0; i < LANES; i++) begin
         int s;
         s = 0;
         for (int k = 0; k < KLEN; k++) s += pix_a[k] * w_a[k][i];
         if (relu_a[KLEN-1] && s < 0) s = 0;
         exp_r[i] = s;
      end
   endtask

   task automatic fill_basic();
      for (int k = 0; k < KLEN; k++) begin
         pix_a[k] = k + 1;
         w_a[k][0] = 1; w_a[k][1] = -1; w_a[k][2] = 2; w_a[k][3] = 0;
         relu_a[k] = 1'b0;
      end
   endtask

   task automatic fill_const(input int p, input int w);
      for (int k = 0; k < KLEN; k++) begin
         pix_a[k] = p;
         for (int i = 0; i < LANES; i++) w_a[k][i] = w;
         relu_a[k] = 1'b0;
      end
   endtask

   task automatic fill_random();
      for (int k = 0; k < KLEN; k++) begin
         pix_a[k] = int'($urandom_range(255, 0)) - 128;
         for (int i = 0; i < LANES; i++) w_a[k][i] = int'($urandom_range(255, 0)) - 128;
         relu_a[k] = 1'($urandom_range(1, 0));
      end
   endtask

   // gap_mode: 0 no gaps, 1 two idle cycles between beats, 2 random 0..2 idle cycles
   task automatic feed_window(input int n_beats, input int gap_mode);
      for (int k = 0; k < n_beats; k++) begin
         int gaps;
         gaps = 0;
         if (k > 0 && gap_mode == 1) gaps = 2;
         if (k > 0 && gap_mode == 2) gaps = int'($urandom_range(2, 0));
         for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            pixel = DW'($urandom);
            weights = (LANES*DW)'($urandom);
            relu_en = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            n_vec++;
            if (beat_cnt !== CW'(k)) begin
               n_err++;
               $display("FAIL stall_cnt beat %0d: got %0d want %0d", k, beat_cnt, k);
            end
         end
         @(negedge clk);
         n_vec++;
         if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL in_ready_accum beat %0d: got %b want 1", k, in_ready);
         end
         in_valid = 1'b1;
         pixel = DW'(pix_a[k]);
         for (int i = 0; i < LANES; i++) weights[i*DW +: DW] = DW'(w_a[k][i]);
         relu_en = relu_a[k];
         @(posedge clk); #1;
         if (k < KLEN-1) begin
            n_vec++;
            if (beat_cnt !== CW'(k+1) || out_valid !== 1'b0 || busy !== 1'b1) begin
               n_err++;
               $display("FAIL beat_cnt beat %0d: got cnt=%0d ov=%b busy=%b want cnt=%0d ov=0 busy=1",
                        k, beat_cnt, out_valid, busy, k+1);
            end
         end else begin
            n_vec++;
            if (beat_cnt !== '0 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
               n_err++;
               $display("FAIL final_beat: got cnt=%0d ov=%b rdy=%b busy=%b want cnt=0 ov=1 rdy=0 busy=1",
                        beat_cnt, out_valid, in_ready, busy);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic check_result(input string tag);
      compute_expected();
      for (int i = 0; i < LANES; i++) begin
         logic [AW-1:0] e;
         e = exp_r[i][AW-1:0];
         n_vec++;
         if (out_data[i*AW +: AW] !== e) begin
            n_err++;
            $display("FAIL %s lane %0d: got %0d want %0d", tag, i,
                     $signed(out_data[i*AW +: AW]), exp_r[i]);
         end
         last_r[i] = exp_r[i];
      end
   endtask

   task automatic release_result(input int hold_cycles);
      logic [LANES*AW-1:0] snap;
      snap = out_data;
      for (int c = 0; c < hold_cycles; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         @(posedge clk); #1;
         n_vec++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== snap) begin
            n_err++;
            $display("FAIL hold cycle %0d: got ov=%b rdy=%b data=%h want ov=1 rdy=0 data=%h",
                     c, out_valid, in_ready, out_data, snap);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL handshake: got ov=%b busy=%b rdy=%b want ov=0 busy=0 rdy=1",
                  out_valid, busy, in_ready);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_vec++;
      if (out_valid !== 1'b0 || beat_cnt !== '0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== '0) begin
         n_err++;
         $display("FAIL reset_state: got ov=%b cnt=%0d rdy=%b busy=%b data=%h want 0/0/1/0/0",
                  out_valid, beat_cnt, in_ready, busy, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      fill_basic();
      feed_window(KLEN, 0);
      check_result("basic");
      release_result(0);
   endtask

   task automatic test_relu();
      fill_basic();
      relu_a[KLEN-1] = 1'b1;
      feed_window(KLEN, 0);
      check_result("relu_final");
      release_result(0);
      fill_basic();
      for (int k = 0; k < KLEN-1; k++) relu_a[k] = 1'b1;
      feed_window(KLEN, 0);
      check_result("relu_early_only");
      release_result(0);
   endtask

   task automatic test_extremes();
      fill_const(-128, -128);
      feed_window(KLEN, 0);
      check_result("ext_pos");
      release_result(0);
      fill_const(-128, 127);
      feed_window(KLEN, 0);
      check_result("ext_neg");
      release_result(0);
   endtask

   task automatic test_stalls();
      fill_basic();
      feed_window(KLEN, 1);
      check_result("stall");
      release_result(0);
   endtask

   task automatic test_backpressure();
      fill_random();
      feed_window(KLEN, 0);
      check_result("backpressure");
      release_result(5);
      fill_basic();
      feed_window(KLEN, 0);
      check_result("back_to_back");
      release_result(0);
   endtask

   task automatic test_clear();
      fill_random();
      feed_window(4, 0);
      @(negedge clk);
      clear = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (beat_cnt !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL clear_state: got cnt=%0d busy=%b ov=%b want 0/0/0", beat_cnt, busy, out_valid);
      end
      for (int i = 0; i < LANES; i++) begin
         logic [AW-1:0] e;
         e = last_r[i][AW-1:0];
         n_vec++;
         if (out_data[i*AW +: AW] !== e) begin
            n_err++;
            $display("FAIL clear_keeps_data lane %0d: got %0d want %0d", i,
                     $signed(out_data[i*AW +: AW]), last_r[i]);
         end
      end
      clear = 1'b0;
      in_valid = 1'b0;
      fill_basic();
      feed_window(KLEN, 0);
      check_result("after_clear");
      release_result(0);
   endtask

   task automatic test_async_reset();
      fill_random();
      feed_window(KLEN, 0);
      check_result("pre_reset");
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== '0 || beat_cnt !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got ov=%b data=%h cnt=%0d rdy=%b busy=%b want 0/0/0/1/0",
                  out_valid, out_data, beat_cnt, in_ready, busy);
      end
      rst = 1'b0;
      fill_basic();
      feed_window(KLEN, 0);
      check_result("post_reset");
      release_result(0);
   endtask

   task automatic test_random();
      for (int w = 0; w < 16; w++) begin
         fill_random();
         feed_window(KLEN, 2);
         check_result("random");
         release_result(int'($urandom_range(3, 0)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_extremes();
      test_stalls();
      test_backpressure();
      test_clear();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
